// File: rtl/mem_ctrl_dual_rank_if.sv
// Host request/response handshake bundle for the dual-rank memory controller.
// The master side issues requests and consumes read data; the slave side is the controller.
interface mem_ctrl_dual_rank_if #(
  parameter int BANKADDR_WIDTH = 9,
  parameter int DATA_WIDTH     = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [BANKADDR_WIDTH:0] req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_ctrl_dual_rank.sv
// Single-outstanding controller for two byte-wide ranks; write frees in 2 cycles, read data valid from cycle 3.
// One request in flight: req_ready only in IDLE, and the read response is held until rsp_ready.
module mem_ctrl_dual_rank #(
  parameter int BANKADDR_WIDTH = 9,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_ctrl_dual_rank_if.slave       host,
  output logic [BANKADDR_WIDTH-1:0] r0_bankAddr,
  output logic [BANKADDR_WIDTH-1:0] r1_bankAddr,
  output logic [DATA_WIDTH-1:0]     r0_dataIn,
  output logic [DATA_WIDTH-1:0]     r1_dataIn,
  output logic                      r0_wr,
  output logic                      r1_wr,
  output logic                      r0_be,
  output logic                      r1_be,
  input  logic [DATA_WIDTH-1:0]     r0_dataOut,
  input  logic [DATA_WIDTH-1:0]     r1_dataOut,
  output logic [15:0]               wr_count,
  output logic [15:0]               rd_count
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]              state_q,  state_d;
  logic [BANKADDR_WIDTH:0] addr_q,   addr_d;
  logic                    wr_q,     wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;

  logic rank_sel;
  logic rank_active;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          addr_d  = host.req_addr;
          wr_d    = host.req_wr;
          wdata_d = host.req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = wr_q ? IDLE : CAPTURE;
        if (wr_q && (wr_cnt_q != 16'hFFFF)) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
      CAPTURE: begin
        // The rank registered its byte at the end of ACCESS; sample it here.
        rdata_d = rank_sel ? r1_dataOut : r0_dataOut;
        state_d = RESP;
      end
      RESP: begin
        if (host.rsp_ready) begin
          state_d = IDLE;
          if (rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rank_sel    = addr_q[BANKADDR_WIDTH];
  assign rank_active = (state_q == ACCESS) || (state_q == CAPTURE);

  assign r0_be = rank_active && !rank_sel;
  assign r1_be = rank_active &&  rank_sel;
  assign r0_wr = r0_be && (state_q == ACCESS) && wr_q;
  assign r1_wr = r1_be && (state_q == ACCESS) && wr_q;

  assign r0_bankAddr = addr_q[BANKADDR_WIDTH-1:0];
  assign r1_bankAddr = addr_q[BANKADDR_WIDTH-1:0];
  assign r0_dataIn   = wdata_q;
  assign r1_dataIn   = wdata_q;

  assign host.req_ready = (state_q == IDLE);
  assign host.rsp_valid = (state_q == RESP);
  assign host.rsp_rdata = rdata_q;

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
endmodule

// File: doc/mem_ctrl_dual_rank.md
MEM_CTRL_DUAL_RANK -- requirements
Module: mem_ctrl_dual_rank

Interface
REQ-001 SHALL have parameter BANKADDR_WIDTH, default 9, the per-rank address width: bank [8:7] plus byte address [6:0].
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the data byte width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  BANKADDR_WIDTH+1  bit [9] rank select; bits [8:0] per-rank bankAddr.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  host accepts read data.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 r0_bankAddr / r1_bankAddr  output  BANKADDR_WIDTH  rank 0/1 address.
REQ-015 r0_dataIn / r1_dataIn  output  DATA_WIDTH  rank 0/1 write data.
REQ-016 r0_wr / r1_wr  output  1  rank 0/1 write enable.
REQ-017 r0_be / r1_be  output  1  rank 0/1 bank enable.
REQ-018 r0_dataOut / r1_dataOut  input  DATA_WIDTH  rank 0/1 read data.
REQ-019 wr_count, rd_count  output  16 each  completed writes / completed reads.

Function
REQ-020 Rank model: a rank writes dataIn on a clk edge with be=1, wr=1; on an edge with be=1, wr=0 it registers the addressed byte onto dataOut.
REQ-021 FSM states: IDLE, ACCESS, CAPTURE, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-023 IDLE: on req_valid=1, latch addr, wr and wdata, then go to ACCESS.
REQ-024 ACCESS: selected rank be=1, wr=latched wr, bankAddr=latched addr[8:0], dataIn=latched wdata.
REQ-025 ACCESS exits to IDLE for a write, to CAPTURE for a read.
REQ-026 CAPTURE: selected rank be=1, wr=0, same address.
REQ-027 CAPTURE: selected rank dataOut registered into rsp_rdata at the cycle end; go to RESP.
REQ-028 RESP: rsp_valid=1 and rsp_rdata held stable until rsp_ready=1, then go to IDLE.
REQ-029 The unselected rank SHALL have be=0 and wr=0 in all states.
REQ-030 In IDLE and RESP both ranks SHALL have be=0 and wr=0.
REQ-031 bankAddr and dataIn on both ranks SHALL reflect the latched values at all times.
REQ-032 Latency, accept edge = cycle 0: write occupies ACCESS in cycle 1 and req_ready returns in cycle 2.
REQ-033 Latency: read rsp_valid rises in cycle 3 at the earliest; the next accept is possible in the cycle after the rsp handshake.
REQ-034 Requests arriving while req_ready=0 are ignored; the host holds them.
REQ-035 A write does not produce a response.
REQ-036 wr_count increments on leaving ACCESS with a write; rd_count increments on the RESP handshake.
REQ-037 Both counters saturate at 16'hFFFF and do not wrap.
REQ-038 Back-to-back writes are accepted every 2 cycles.
REQ-039 Address values 0x000 and 0x3FF SHALL map to rank 0 bank 0 addr 0x00 and rank 1 bank 3 addr 0x7F.

Reset
REQ-040 With rst=1 at a clk edge: state=IDLE, all r*_be=0 and r*_wr=0, bankAddr=0, dataIn=0.
REQ-041 With rst=1 at a clk edge: rsp_valid=0, rsp_rdata=0, wr_count=0, rd_count=0.
REQ-042 rst in any state SHALL abort the in-flight transaction with no rank write after the reset edge and no response.
REQ-043 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-044 Write addr 0x0A5, data 0x3C, then read 0x0A5 -> r0_be=1, r0_wr=1 one cycle; r1_be never 1; rsp_rdata=0x3C, rsp_valid rises at cycle 3; wr_count=1, rd_count=1.
REQ-045 Write 0x11 to 0x2A5 and 0x22 to 0x0A5, then read both -> rank 1 returns 0x11, rank 0 returns 0x22 (rank isolation).
REQ-046 Same write/read pair at each bank 0-3 of rank 1, addr 0x7F -> data returned per bank; bankAddr[8:7] equals the bank number during ACCESS.
REQ-047 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable; req_ready=0; a new req_valid is not accepted until the handshake.
REQ-048 Assert rst during CAPTURE of a read -> next cycle: IDLE, rsp_valid=0, be=0 on both ranks, rd_count unchanged at 0.
REQ-049 Preload wr_count to 0xFFFE via 0xFFFE writes, then 3 more writes -> wr_count=0xFFFF, no wrap.
